sand_row_stream: RTL and testbench

Streaming, parametrised successor to the per-word combinational sand update. It consumes row-pair words (region row plus the floor row below) on a valid/ready stream, applies one physics step across an entire row, and emits updated words. Sand can move diagonally across word boundaries, tie-breaking alternates each frame, and backpressure is supported. It sits between the framebuffer read DMA and the write-back path.

---
 rtl/sand_pkg.sv | 28 ++
 rtl/sand_row_stream_kernel.sv | 103 ++++++++++
 rtl/sand_row_stream.sv | 163 ++++++++++++++++
 tb/tb_sand_row_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// Shared cell encoding and word unpacking for the streaming sand row update.
// Words are left-aligned: cell 0 (leftmost) sits in the most significant pair.
package sand_pkg;

    localparam int CELL_W    = 2;
    localparam int MAX_CELLS = 64;

    typedef enum logic [CELL_W-1:0] {
        AIR     = 2'd0,
        SAND    = 2'd1,
        SAND_AM = 2'd2,
        WALL    = 2'd3
    } cell_t;

    typedef cell_t cell_vec_t [MAX_CELLS];

    // Unpack the low n cells of a zero-extended word; cell 0 is the leftmost.
    function automatic cell_vec_t unpack_word(input logic [CELL_W*MAX_CELLS-1:0] w,
                                              input int n);
        cell_vec_t v;
        for (int i = 0; i < MAX_CELLS; i++) begin
            v[i] = AIR;
            if (i < n) v[i] = cell_t'(w[CELL_W*(n-1-i) +: CELL_W]);
        end
        return v;
    endfunction

endpackage

// File: rtl/sand_row_stream_kernel.sv
// sand_word_kernel: combinational left-to-right sand step over one word, including
// resolution of a right-edge move pending from the word to its left.
module sand_word_kernel
    import sand_pkg::*;
#(
    parameter int CELLS = 16,
    parameter int COL_W = 1,
    localparam int W      = CELL_W * CELLS,
    localparam int MOVE_W = $clog2(CELLS + 2)
) (
    input  logic [W-1:0]      region,
    input  logic [W-1:0]      floor,
    input  logic [COL_W-1:0]  col_base,
    input  logic              parity,
    input  logic              first,
    input  logic              last,
    input  logic              pend_in,
    input  logic              pend_fb_in,
    input  logic              left_air,
    output logic [W-1:0]      region_upd,
    output logic [W-1:0]      floor_upd,
    output logic              pend_out,
    output logic              pend_fb_out,
    output logic              pend_right,
    output logic              pend_left,
    output logic              left_write,
    output logic [MOVE_W-1:0] moves
);

    logic [CELL_W*MAX_CELLS-1:0] ext_r, ext_f;
    cell_vec_t                   rg, fl;
    logic [COL_W-1:0]            c;
    logic                        pref_left, l_ok, r_ok;

    always_comb begin
        ext_r = '0;
        ext_f = '0;
        ext_r[W-1:0] = region;
        ext_f[W-1:0] = floor;
        rg = unpack_word(ext_r, CELLS);
        fl = unpack_word(ext_f, CELLS);
        pend_out    = 1'b0;
        pend_fb_out = 1'b0;
        pend_right  = 1'b0;
        pend_left   = 1'b0;
        left_write  = 1'b0;
        moves       = '0;
        c           = '0;
        pref_left   = 1'b0;
        l_ok        = 1'b0;
        r_ok        = 1'b0;

        // The previous word's last cell moves before anything in this word is scanned.
        if (pend_in) begin
            if (!first && fl[0] == AIR) begin
                fl[0]      = SAND_AM;
                pend_right = 1'b1;
                moves      = moves + MOVE_W'(1);
            end else if (pend_fb_in) begin
                pend_left = 1'b1;
                moves     = moves + MOVE_W'(1);
            end
        end

        for (int i = 0; i < CELLS; i++) begin
            c         = col_base + COL_W'(i);
            pref_left = c[0] ^ parity;
            l_ok      = (i == 0) ? (!first && left_air) : (fl[(i == 0) ? 0 : i - 1] == AIR);
            r_ok      = (i == CELLS - 1) ? 1'b0 : (fl[(i == CELLS - 1) ? i : i + 1] == AIR);
            if (rg[i] == SAND_AM) begin
                rg[i] = SAND;
            end else if (rg[i] == SAND) begin
                if (fl[i] == AIR) begin
                    rg[i] = AIR;
                    fl[i] = SAND_AM;
                    moves = moves + MOVE_W'(1);
                end else if ((pref_left && l_ok) ||
                             (!pref_left && !r_ok && l_ok && (i != CELLS - 1 || last))) begin
                    rg[i] = AIR;
                    if (i == 0) left_write = 1'b1;
                    else        fl[(i == 0) ? 0 : i - 1] = SAND_AM;
                    moves = moves + MOVE_W'(1);
                end else if (r_ok) begin
                    rg[i] = AIR;
                    fl[(i == CELLS - 1) ? i : i + 1] = SAND_AM;
                    moves = moves + MOVE_W'(1);
                end else if (i == CELLS - 1 && !last) begin
                    // Right target lives in the next word; left stays as the fallback.
                    pend_out    = 1'b1;
                    pend_fb_out = !pref_left && l_ok;
                end
            end
        end

        region_upd = '0;
        floor_upd  = '0;
        for (int i = 0; i < CELLS; i++) begin
            region_upd[CELL_W*(CELLS-1-i) +: CELL_W] = rg[i];
            floor_upd[CELL_W*(CELLS-1-i) +: CELL_W]  = fl[i];
        end
    end

endmodule

// File: rtl/sand_row_stream.sv
// Streaming sand row update: holding register H, output register O, handshake,
// move counter and frame parity. Build with SAND_SPOUT_EN to add the spout input.
module sand_row_stream
    import sand_pkg::*;
#(
    parameter int CELLS         = 16,
    parameter int MAX_ROW_WORDS = 40,
    parameter int SPOUT_LO      = 120,
    parameter int SPOUT_HI      = 127,
    localparam int W            = CELL_W * CELLS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_tick,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    input  logic [W-1:0] in_region,
    input  logic [W-1:0] in_floor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last,
    output logic [W-1:0] out_region,
    output logic [W-1:0] out_floor,
    output logic [15:0]  move_count,
    output logic         frame_parity
`ifdef SAND_SPOUT_EN
    ,
    input  logic         spout
`endif
);

    localparam int COL_W  = $clog2(MAX_ROW_WORDS * CELLS + 1);
    localparam int MOVE_W = $clog2(CELLS + 2);

    logic             h_valid, h_first, h_last, h_pend, h_pend_fb, h_spout;
    logic [W-1:0]     h_region, h_floor, h_region_fin, h_floor_fin;
    logic [COL_W-1:0] h_col, col_next, col_base;
    logic             accept, drain, o_free, parity_eff, left_air, spout_req;
    logic [W-1:0]     k_region, k_floor;
    logic             k_pend, k_pend_fb, k_pend_right, k_pend_left, k_left_write;
    logic [MOVE_W-1:0] k_moves;
    logic [15:0]      mc_base;
    logic [16:0]      mc_sum;
    int               colv;

    assign in_ready   = !(out_valid && !out_ready) && !(h_valid && h_last);
    assign accept     = in_valid && in_ready;
    assign o_free     = !out_valid || out_ready;
    assign drain      = h_valid && h_last && o_free;
    assign parity_eff = frame_parity ^ frame_tick;
    assign col_base   = in_first ? '0 : col_next;
    assign left_air   = h_valid && (h_floor[CELL_W-1:0] == AIR);

`ifdef SAND_SPOUT_EN
    logic first_row;

    assign spout_req = spout && (first_row || frame_tick);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                first_row <= 1'b0;
        else if (accept && in_last)  first_row <= 1'b0;
        else if (frame_tick)         first_row <= 1'b1;
    end
`else
    assign spout_req = 1'b0;
`endif

    // Only the parity of the column base matters inside the kernel.
    sand_word_kernel #(
        .CELLS (CELLS),
        .COL_W (1)
    ) u_kernel (
        .region     (in_region),
        .floor      (in_floor),
        .col_base   (col_base[0]),
        .parity     (parity_eff),
        .first      (in_first),
        .last       (in_last),
        .pend_in    (h_valid && h_pend),
        .pend_fb_in (h_pend_fb),
        .left_air   (left_air),
        .region_upd (k_region),
        .floor_upd  (k_floor),
        .pend_out   (k_pend),
        .pend_fb_out(k_pend_fb),
        .pend_right (k_pend_right),
        .pend_left  (k_pend_left),
        .left_write (k_left_write),
        .moves      (k_moves)
    );

    always_comb begin
        h_region_fin = h_region;
        h_floor_fin  = h_floor;
        colv         = 0;
        if (accept) begin
            if (k_pend_right || k_pend_left) h_region_fin[CELL_W-1:0] = AIR;
            if (k_pend_left)  h_floor_fin[2*CELL_W-1:CELL_W] = SAND_AM;
            if (k_left_write) h_floor_fin[CELL_W-1:0]        = SAND_AM;
        end
        for (int i = 0; i < CELLS; i++) begin
            colv = int'(h_col) + i;
            if (h_spout && colv >= SPOUT_LO && colv <= SPOUT_HI &&
                h_region_fin[CELL_W*(CELLS-1-i) +: CELL_W] == AIR)
                h_region_fin[CELL_W*(CELLS-1-i) +: CELL_W] = SAND;
        end
    end

    assign mc_base = frame_tick ? 16'h0000 : move_count;
    assign mc_sum  = {1'b0, mc_base} + (accept ? 17'(k_moves) : 17'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_valid      <= 1'b0;
            h_first      <= 1'b0;
            h_last       <= 1'b0;
            h_pend       <= 1'b0;
            h_pend_fb    <= 1'b0;
            h_spout      <= 1'b0;
            h_region     <= '0;
            h_floor      <= '0;
            h_col        <= '0;
            col_next     <= '0;
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_region   <= '0;
            out_floor    <= '0;
            move_count   <= '0;
            frame_parity <= 1'b0;
        end else begin
            if (accept) begin
                h_valid   <= 1'b1;
                h_first   <= in_first;
                h_last    <= in_last;
                h_pend    <= k_pend;
                h_pend_fb <= k_pend_fb;
                h_spout   <= spout_req;
                h_region  <= k_region;
                h_floor   <= k_floor;
                h_col     <= col_base;
                col_next  <= col_base + COL_W'(CELLS);
            end else if (drain) begin
                h_valid <= 1'b0;
            end
            if ((accept && h_valid) || drain) begin
                out_valid  <= 1'b1;
                out_first  <= h_first;
                out_last   <= h_last;
                out_region <= h_region_fin;
                out_floor  <= h_floor_fin;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (frame_tick) frame_parity <= ~frame_parity;
            move_count <= mc_sum[16] ? 16'hFFFF : mc_sum[15:0];
        end
    end

endmodule

// File: tb/tb_sand_row_stream.sv
// Scoreboard bench for sand_row_stream: directed words with hand-computed results.
module tb_sand_row_stream;

    localparam int CELLS = 16;
    localparam int W     = 2 * CELLS;
    localparam logic [W-1:0] ALLW = '1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic [W-1:0] in_region = '0;
    logic [W-1:0] in_floor = '0;
    logic         out_ready = 1'b1;
    logic         in_ready, out_valid, out_first, out_last, frame_parity;
    logic [W-1:0] out_region, out_floor;
    logic [15:0]  move_count;

    sand_row_stream #(.CELLS(CELLS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_last     (in_last),
        .in_region   (in_region),
        .in_floor    (in_floor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_first   (out_first),
        .out_last    (out_last),
        .out_region  (out_region),
        .out_floor   (out_floor),
        .move_count  (move_count),
        .frame_parity(frame_parity)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         first;
        logic         last;
        logic [W-1:0] region;
        logic [W-1:0] floor;
    } word_t;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_popped = 0;

    function automatic logic [W-1:0] cl(input int i, input logic [1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[2*(CELLS-1-i) +: 2] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: a word is consumed at the next rising edge when valid and ready.
    always @(negedge clk) begin
        word_t e;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got region %h floor %h, expected no output",
                         out_region, out_floor);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                check("out_first",  W'(out_first), W'(e.first));
                check("out_last",   W'(out_last),  W'(e.last));
                check("out_region", out_region,    e.region);
                check("out_floor",  out_floor,     e.floor);
            end
        end
    end

    task automatic send(input logic f, input logic l, input logic [W-1:0] r, input logic [W-1:0] fl,
                        input logic [W-1:0] er, input logic [W-1:0] efl, input logic tick);
        int  n;
        logic done;
        exp_q.push_back('{first: f, last: l, region: er, floor: efl});
        in_first   = f;
        in_last    = l;
        in_region  = r;
        in_floor   = fl;
        in_valid   = 1'b1;
        frame_tick = tick;
        n    = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            frame_tick = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed low, expected accept within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: %0d words still expected, expected all delivered", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  W'(out_valid),    '0);
        check("rst_out_region", out_region,       '0);
        check("rst_out_floor",  out_floor,        '0);
        check("rst_out_first",  W'(out_first),    '0);
        check("rst_out_last",   W'(out_last),     '0);
        check("rst_move_count", W'(move_count),   '0);
        check("rst_parity",     W'(frame_parity), '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", W'(in_ready), W'(1));

        // Straight fall into air.
        send(1, 1, cl(5, 1), '0, '0, cl(5, 2), 0);
        wait_idle();
        check("mc_fall", W'(move_count), W'(1));

        // Blocked below, parity 0: column 5 prefers left.
        send(1, 1, cl(5, 1), ALLW & ~cl(4, 3) & ~cl(6, 3),
             '0, ALLW & ~cl(4, 3) & ~cl(6, 3) | cl(4, 2), 0);
        wait_idle();
        check("mc_left", W'(move_count), W'(2));

        // Same word with frame_tick on the accept: new parity, count restarts at 1.
        send(1, 1, cl(5, 1), ALLW & ~cl(4, 3) & ~cl(6, 3),
             '0, ALLW & ~cl(4, 3) & ~cl(6, 3) | cl(6, 2), 1);
        wait_idle();
        check("mc_tick", W'(move_count), W'(1));
        check("parity_tick", W'(frame_parity), W'(1));

        // Pending right move across the word boundary.
        send(1, 0, cl(15, 1), ALLW, '0, ALLW, 0);
        send(0, 1, '0, ALLW & ~cl(0, 3), '0, ALLW & ~cl(0, 3) | cl(0, 2), 0);
        wait_idle();
        check("mc_cross_right", W'(move_count), W'(2));

        // Right target blocked in the next word: fall back to the left diagonal.
        send(1, 0, cl(15, 1), ALLW & ~cl(14, 3), '0, ALLW & ~cl(14, 3) | cl(14, 2), 0);
        send(0, 1, '0, ALLW, '0, ALLW, 0);
        wait_idle();
        check("mc_fallback", W'(move_count), W'(3));

        // Cell 0 of word 1 moves left into the held word's last floor cell.
        send(1, 0, '0, ALLW & ~cl(15, 3), '0, ALLW & ~cl(15, 3) | cl(15, 2), 0);
        send(0, 1, cl(0, 1), ALLW, '0, ALLW, 0);
        wait_idle();
        check("mc_cross_left", W'(move_count), W'(4));

        // Backpressure: O held for 5 cycles, nothing lost, order kept.
        base = n_popped;
        out_ready = 1'b0;
        send(1, 0, cl(0, 3), 32'hA5A5_0000, cl(0, 3), 32'hA5A5_0000, 0);
        send(0, 0, cl(1, 3), 32'hA5A5_0001, cl(1, 3), 32'hA5A5_0001, 0);
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_region = cl(2, 3);
        in_floor  = 32'hA5A5_0002;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready",   W'(in_ready),  '0);
            check("stall_out_valid",  W'(out_valid), W'(1));
            check("stall_out_region", out_region,    cl(0, 3));
            check("stall_out_floor",  out_floor,     32'hA5A5_0000);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(0, 0, cl(2, 3), 32'hA5A5_0002, cl(2, 3), 32'hA5A5_0002, 0);
        send(0, 1, cl(3, 3), 32'hA5A5_0003, cl(3, 3), 32'hA5A5_0003, 0);
        wait_idle();
        check("stall_word_count", W'(n_popped - base), W'(4));
        check("mc_stall", W'(move_count), W'(4));

        // Reset with H and O both occupied.
        out_ready = 1'b0;
        send(1, 0, cl(5, 1), '0, '0, cl(5, 2), 0);
        send(0, 0, '0, '0, '0, '0, 0);
        check("mc_before_reset", W'(move_count), W'(5));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid),    '0);
        check("mid_rst_mc",        W'(move_count),   '0);
        check("mid_rst_parity",    W'(frame_parity), '0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(1, 1, cl(5, 1), '0, '0, cl(5, 2), 0);
        wait_idle();
        check("mc_after_reset", W'(move_count), W'(1));

        // Single-word row: no left neighbour for cell 0, no right for cell 15.
        send(1, 1, cl(0, 1) | cl(15, 1), ALLW, cl(0, 1) | cl(15, 1), ALLW, 0);
        wait_idle();
        check("mc_edges", W'(move_count), W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
